// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

   localparam int CNT_W_DEFAULT = 8;
   localparam int MIN_DIV       = 2;

   typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider: registered ceil-half-duty clock,
// per-period tick, ratio reload applied only at the period boundary.
module clk_divider_prog
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_active,
   output logic             div_err
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_active;
   logic [CNT_W-1:0] r_pend;
   logic             r_pend_vld;
   logic             r_div_err;
   logic             r_clk_out;
   logic             r_tick;

   logic             w_load_ok;
   logic             w_wrap;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_div_nxt;

   // (N+1)>>1 without the carry out of N+1, so N=2^CNT_W-1 stays in range
   function automatic logic [CNT_W-1:0] ceil_half(input logic [CNT_W-1:0] n);
      return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
   endfunction

   assign w_load_ok = div_load && (div_val >= DIV_MIN);
   assign w_wrap    = en && (r_cnt == r_div_active - DIV_ONE);

   always_comb begin
      w_cnt_nxt = r_cnt;
      w_div_nxt = r_div_active;
      if (en) begin
         if (w_wrap) begin
            w_cnt_nxt = '0;
            if (w_load_ok) begin
               w_div_nxt = div_val;
            end else if (r_pend_vld) begin
               w_div_nxt = r_pend;
            end
         end else begin
            w_cnt_nxt = r_cnt + DIV_ONE;
         end
      end
   end

   // ratio shadow register and wrap counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= DIV_RST - DIV_ONE;
         r_div_active <= DIV_RST;
         r_pend_vld   <= 1'b0;
         r_div_err    <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_div_active <= w_div_nxt;
         r_div_err    <= div_load && (div_val < DIV_MIN);
         if (w_wrap) begin
            r_pend_vld <= 1'b0;
         end else if (w_load_ok) begin
            r_pend_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_load_ok && !w_wrap) begin
         r_pend <= div_val;
      end
   end

   // output decode from next-count so outputs move on the same edge as the counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else if (en) begin
         r_clk_out <= (w_cnt_nxt < ceil_half(w_div_nxt));
         r_tick    <= (w_cnt_nxt == w_div_nxt - DIV_ONE);
      end else begin
         r_tick    <= 1'b0;
      end
   end

   assign clk_out    = r_clk_out;
   assign tick       = r_tick;
   assign div_active = r_div_active;
   assign div_err    = r_div_err;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog with a cycle-level reference model and scoreboard.
module tb_clk_divider_prog;
   import clk_div_pkg::*;

   localparam int DEF_DIV = 6;

   typedef struct packed {
      logic       clk_out;
      logic       tick;
      logic [7:0] div_active;
      logic       div_err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   div_t       div_val = '0;
   logic       div_load = 1'b0;
   logic       clk_out;
   logic       tick;
   div_t       div_active;
   logic       div_err;

   clk_divider_prog #(.CNT_W(8), .DEFAULT_DIV(DEF_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .div_val    (div_val),
      .div_load   (div_load),
      .clk_out    (clk_out),
      .tick       (tick),
      .div_active (div_active),
      .div_err    (div_err)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // reference model state (plain integers, spec-level)
   int   m_cnt, m_n, m_pend;
   bit   m_pv, m_clk;

   // window counters for directed checks
   int   w_hi, w_tick, w_err;
   bit   seen9;

   task automatic check_bit(input string tag, input logic got, input logic exp_v);
      n_tests++;
      assert (got === exp_v) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp_v);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp_v);
      n_tests++;
      assert (got === exp_v) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp_v);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic l, input int v);
      exp_t ex;
      exp_t got;
      bit   ld_ok;
      rst      = r;
      en       = e;
      div_load = l;
      div_val  = div_t'(v);
      ld_ok    = l && (v >= MIN_DIV);
      ex.div_err = 1'b0;
      ex.tick    = 1'b0;
      if (r) begin
         m_cnt = DEF_DIV - 1;
         m_n   = DEF_DIV;
         m_pv  = 1'b0;
         m_clk = 1'b0;
      end else begin
         ex.div_err = l && (v < MIN_DIV);
         if (e && m_cnt == m_n - 1) begin
            m_cnt = 0;
            if (ld_ok) m_n = v;
            else if (m_pv) m_n = m_pend;
            m_pv = 1'b0;
         end else begin
            if (e) m_cnt = m_cnt + 1;
            if (ld_ok) begin
               m_pend = v;
               m_pv   = 1'b1;
            end
         end
         if (e) begin
            m_clk   = (m_cnt < (m_n + 1) / 2);
            ex.tick = (m_cnt == m_n - 1);
         end
      end
      ex.clk_out    = m_clk;
      ex.div_active = 8'(m_n);
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      cyc++;
      got.clk_out    = clk_out;
      got.tick       = tick;
      got.div_active = div_active;
      got.div_err    = div_err;
      ex = sb_q.pop_front();
      check_bit("clk_out", got.clk_out, ex.clk_out);
      check_bit("tick", got.tick, ex.tick);
      check_int("div_active", int'(got.div_active), int'(ex.div_active));
      check_bit("div_err", got.div_err, ex.div_err);
      if (clk_out === 1'b1) w_hi++;
      if (tick === 1'b1) w_tick++;
      if (div_err === 1'b1) w_err++;
      if (div_active === 8'd9) seen9 = 1'b1;
   endtask

   task automatic clr_win();
      w_hi = 0; w_tick = 0; w_err = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
   endtask

   initial begin
      seen9 = 1'b0;
      clr_win();
      // reset state
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);

      // default ratio: two full periods of 3 high / 3 low, one tick each
      clr_win();
      run(12);
      check_int("def_high_cycles", w_hi, 6);
      check_int("def_ticks", w_tick, 2);

      // reload 5 mid-period; old period completes first
      run(2);
      step(1'b0, 1'b1, 1'b1, 5);
      check_int("active_still_6", int'(div_active), 6);
      run(10);
      check_int("active_5", int'(div_active), 5);
      clr_win();
      run(10);
      check_int("n5_high_cycles", w_hi, 6);
      check_int("n5_ticks", w_tick, 2);

      // 9 then 4 before one wrap: only 4 takes effect
      step(1'b0, 1'b1, 1'b1, 9);
      step(1'b0, 1'b1, 1'b1, 4);
      run(12);
      check_int("seen9", int'(seen9), 0);
      check_int("active_4", int'(div_active), 4);

      // illegal ratios flag an error and leave the ratio alone
      clr_win();
      step(1'b0, 1'b1, 1'b1, 1);
      step(1'b0, 1'b1, 1'b1, 0);
      run(12);
      check_int("err_pulses", w_err, 2);
      check_int("active_after_err", int'(div_active), 4);

      // freeze for 7 cycles right after clk_out rises
      for (int i = 0; i < 20 && m_cnt != 0; i++) run(1);
      check_int("sync_to_rise", m_cnt, 0);
      clr_win();
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 0);
      check_int("frozen_high", w_hi, 7);
      check_int("frozen_ticks", w_tick, 0);
      run(8);

      // load coinciding with the wrap edge governs the new period
      for (int i = 0; i < 20 && m_cnt != m_n - 1; i++) run(1);
      step(1'b0, 1'b1, 1'b1, 7);
      check_int("active_7_at_wrap", int'(div_active), 7);
      run(14);

      // reset mid-period drops a pending ratio
      step(1'b0, 1'b1, 1'b1, 3);
      run(1);
      step(1'b1, 1'b1, 1'b0, 0);
      check_bit("rst_clk_out", clk_out, 1'b0);
      check_int("rst_active", int'(div_active), 6);
      clr_win();
      run(12);
      check_int("post_rst_high", w_hi, 6);

      // boundary ratios: minimum and maximum
      step(1'b0, 1'b1, 1'b1, 2);
      run(10);
      clr_win();
      run(8);
      check_int("n2_high", w_hi, 4);
      check_int("n2_ticks", w_tick, 4);
      step(1'b0, 1'b1, 1'b1, 255);
      run(4);
      for (int i = 0; i < 20 && m_cnt != 0; i++) run(1);
      clr_win();
      run(255);
      check_int("n255_high", w_hi, 128);
      check_int("n255_ticks", w_tick, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
